// File: rtl/urv_dmem_responder_if.sv
// uRV data-memory bus between the execute stage (master) and a responder.
interface urv_dmem_responder_if;
  logic [31:0] dm_addr;
  logic [31:0] dm_data_s;
  logic [3:0]  dm_data_select;
  logic        dm_store;
  logic        dm_load;
  logic [31:0] dm_data_l;
  logic        dm_load_done;
  logic        dm_store_done;
  logic        dm_busy;
  logic        dm_err;

  modport master (
    output dm_addr, dm_data_s, dm_data_select,
    output dm_store, dm_load,
    input  dm_data_l, dm_load_done, dm_store_done,
    input  dm_busy, dm_err
  );

  modport slave (
    input  dm_addr, dm_data_s, dm_data_select,
    input  dm_store, dm_load,
    output dm_data_l, dm_load_done, dm_store_done,
    output dm_busy, dm_err
  );
endinterface

// File: rtl/urv_dmem_responder.sv
// uRV data-memory responder: local SRAM window with wait states.
// URV_DMEM_ZERO_INIT_EN adds a post-reset zero-fill sweep (INIT).
module urv_dmem_responder #(
  parameter int unsigned g_addr_width  = 10,
  parameter logic [31:0] g_base_addr   = 32'h0000_0000,
  parameter int unsigned g_wait_states = 0
) (
  input logic                 clk_i,
  input logic                 rst_n_i,
  urv_dmem_responder_if.slave dm
);
  localparam int unsigned AW    = g_addr_width;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [3:0]  WS    = 4'(g_wait_states);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
`ifdef URV_DMEM_ZERO_INIT_EN
    , S_INIT
`endif
  } state_e;

`ifdef URV_DMEM_ZERO_INIT_EN
  localparam state_e S_RST    = S_INIT;
  localparam logic   BUSY_RST = 1'b1;
  logic [AW-1:0] ini_q, ini_d;
`else
  localparam state_e S_RST    = S_IDLE;
  localparam logic   BUSY_RST = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          hit_q, hit_d;
  logic          ld_q, ld_d;
  logic          clash_q, clash_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [3:0]    sel_q, sel_d;
  logic [31:0]   rdat_q, rdat_d;
  logic          ldone_q, ldone_d;
  logic          sdone_q, sdone_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;

  logic [3:0][7:0] mem_q [DEPTH];
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [AW-1:0]   mem_wa;
  logic [31:0]     mem_wd;
  logic [31:0]     rd_word;

  logic req;
  logic unused;

  assign req     = dm.dm_load | dm.dm_store;
  assign rd_word = mem_q[idx_q];
  assign unused  = ^dm.dm_addr[1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (req) state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt_q == 4'd1) state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
`ifdef URV_DMEM_ZERO_INIT_EN
      S_INIT: if (&ini_q) state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    ld_d    = ld_q;
    clash_d = clash_q;
    wdat_d  = wdat_q;
    sel_d   = sel_q;
    rdat_d  = rdat_q;
    ldone_d = 1'b0;
    sdone_d = 1'b0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_be  = sel_q;
    mem_wa  = idx_q;
    mem_wd  = wdat_q;
`ifdef URV_DMEM_ZERO_INIT_EN
    ini_d   = ini_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = WS;
          idx_d   = dm.dm_addr[AW+1:2];
          hit_d   = dm.dm_addr[31:AW+2] == g_base_addr[31:AW+2];
          ld_d    = dm.dm_load;
          clash_d = dm.dm_load & dm.dm_store;
          wdat_d  = dm.dm_data_s;
          sel_d   = dm.dm_data_select;
        end
      end
      S_WAIT: begin
        busy_d = 1'b1;
        err_d  = req;
        cnt_d  = cnt_q - 4'd1;
      end
      S_RESP: begin
        busy_d = 1'b1;
        err_d  = req | clash_q | ~hit_q;
        if (ld_q) begin
          ldone_d = 1'b1;
          rdat_d  = hit_q ? rd_word : 32'h0;
        end else begin
          sdone_d = 1'b1;
          mem_we  = hit_q;
        end
      end
`ifdef URV_DMEM_ZERO_INIT_EN
      // busy drops on the last sweep write so it spans exactly DEPTH cycles
      S_INIT: begin
        busy_d = ~&ini_q;
        err_d  = req;
        ini_d  = ini_q + 1'b1;
        mem_we = 1'b1;
        mem_be = 4'hF;
        mem_wa = ini_q;
        mem_wd = 32'h0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      ld_q    <= 1'b0;
      clash_q <= 1'b0;
      wdat_q  <= 32'h0;
      sel_q   <= 4'h0;
      rdat_q  <= 32'h0;
      ldone_q <= 1'b0;
      sdone_q <= 1'b0;
      busy_q  <= BUSY_RST;
      err_q   <= 1'b0;
`ifdef URV_DMEM_ZERO_INIT_EN
      ini_q   <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      ld_q    <= ld_d;
      clash_q <= clash_d;
      wdat_q  <= wdat_d;
      sel_q   <= sel_d;
      rdat_q  <= rdat_d;
      ldone_q <= ldone_d;
      sdone_q <= sdone_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef URV_DMEM_ZERO_INIT_EN
      ini_q   <= ini_d;
`endif
    end
  end

  // contents survive reset; only the sweep clears them
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem_q[mem_wa][b] <= mem_wd[8*b +: 8];
      end
    end
  end

  assign dm.dm_data_l     = rdat_q;
  assign dm.dm_load_done  = ldone_q;
  assign dm.dm_store_done = sdone_q;
  assign dm.dm_busy       = busy_q;
  assign dm.dm_err        = err_q;

endmodule

// File: tb/tb_urv_dmem_responder.sv
// Directed bench for urv_dmem_responder (ws=0 and ws=3 instances,
// plus an aw=4 instance for the zero-fill sweep when enabled).
`timescale 1ns/1ps
module tb_urv_dmem_responder;
`ifdef URV_DMEM_ZERO_INIT_EN
  localparam int   NI      = 3;
  localparam logic INIT_EN = 1'b1;
`else
  localparam int   NI      = 2;
  localparam logic INIT_EN = 1'b0;
`endif
  localparam int D0 = 0;
  localparam int D3 = 1;
  localparam int DI = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] t_addr [NI];
  logic [31:0] t_ds   [NI];
  logic [3:0]  t_sel  [NI];
  logic        t_st   [NI];
  logic        t_ld   [NI];
  logic [31:0] dl     [NI];
  logic        ldn    [NI];
  logic        sdn    [NI];
  logic        bsy    [NI];
  logic        er     [NI];

  for (genvar g = 0; g < NI; g++) begin : gd
    localparam int unsigned AWG = (g == 2) ? 4 : 10;
    localparam int unsigned WSG = (g == 1) ? 3 : 0;
    urv_dmem_responder_if ifc ();
    assign ifc.dm_addr        = t_addr[g];
    assign ifc.dm_data_s      = t_ds[g];
    assign ifc.dm_data_select = t_sel[g];
    assign ifc.dm_store       = t_st[g];
    assign ifc.dm_load        = t_ld[g];
    assign dl[g]  = ifc.dm_data_l;
    assign ldn[g] = ifc.dm_load_done;
    assign sdn[g] = ifc.dm_store_done;
    assign bsy[g] = ifc.dm_busy;
    assign er[g]  = ifc.dm_err;
    urv_dmem_responder #(
      .g_addr_width (AWG),
      .g_base_addr  (32'h0),
      .g_wait_states(WSG)
    ) u_dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .dm     (ifc)
    );
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int          r_lat, r_nb, r_ldn, r_sdn, r_err;
  logic        r_errd;
  logic [31:0] r_dat;

  // i indexes the edge T+i, T being the edge that samples the request
  task automatic access(input int d, input logic l, input logic s,
                        input logic [31:0] ad, input logic [31:0] w,
                        input logic [3:0] se, input int inj);
    t_addr[d] = ad;
    t_ds[d]   = w;
    t_sel[d]  = se;
    t_ld[d]   = l;
    t_st[d]   = s;
    r_lat = 0; r_nb = 0; r_ldn = 0; r_sdn = 0; r_err = 0;
    r_errd = 1'b0;
    r_dat = 32'hxxxx_xxxx;
    for (int i = 0; i <= 8; i++) begin
      step();
      if (i == 0) begin
        t_ld[d] = 1'b0;
        t_st[d] = 1'b0;
      end
      if (inj > 0 && i == inj) t_ld[d] = 1'b1;
      if (inj > 0 && i == inj + 1) t_ld[d] = 1'b0;
      if (bsy[d]) r_nb++;
      if (er[d]) r_err++;
      if (ldn[d]) r_ldn++;
      if (sdn[d]) r_sdn++;
      if ((ldn[d] || sdn[d]) && r_lat == 0) begin
        r_lat  = i;
        r_dat  = dl[d];
        r_errd = er[d];
      end
    end
  endtask

  task automatic wait_init();
    if (INIT_EN) repeat (1040) step();
  endtask

  int nb, ne, nl, ns;

  initial begin
    for (int d = 0; d < NI; d++) begin
      t_addr[d] = 32'h0;
      t_ds[d]   = 32'h0;
      t_sel[d]  = 4'h0;
      t_st[d]   = 1'b0;
      t_ld[d]   = 1'b0;
    end
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      chk("rst_data_l", dl[d], 32'h0);
      chk("rst_done", {30'h0, ldn[d], sdn[d]}, 32'h0);
      chk("rst_err", {31'h0, er[d]}, 32'h0);
      chk("rst_busy", {31'h0, bsy[d]}, {31'h0, INIT_EN});
    end
    rst_n = 1'b1;

`ifdef URV_DMEM_ZERO_INIT_EN
    nb = 0; ne = 0; nl = 0;
    for (int i = 0; i < 1040; i++) begin
      if (bsy[DI]) nb++;
      if (er[DI]) ne++;
      if (ldn[DI]) nl++;
      if (i == 3) begin
        t_addr[DI] = 32'h0;
        t_ld[DI]   = 1'b1;
      end
      if (i == 4) t_ld[DI] = 1'b0;
      step();
    end
    chk("init_busy_cycles", nb, 16);
    chk("init_req_err", ne, 1);
    chk("init_req_no_done", nl, 0);
    for (int w = 0; w < 16; w++) begin
      access(DI, 1'b1, 1'b0, 32'(w * 4), 32'h0, 4'h0, 0);
      chk("init_zero", r_dat, 32'h0);
    end
`else
    nb = 0; ne = 0; nl = 0;
`endif

    access(D0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    chk("ws0_st_lat", r_lat, 1);
    chk("ws0_st_busy", r_nb, 1);
    chk("ws0_st_done", r_sdn, 1);
    chk("ws0_st_err", r_err, 0);
    access(D0, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    chk("ws0_ld_lat", r_lat, 1);
    chk("ws0_ld_data", r_dat, 32'hDEADBEEF);
    chk("ws0_ld_busy", r_nb, 1);
    access(D0, 1'b0, 1'b1, 32'h0, 32'h01020304, 4'hF, 0);
    chk("ws0_ld_hold", dl[D0], 32'hDEADBEEF);

    access(D0, 1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0, 0);
    chk("oow_ld_data", r_dat, 32'h0);
    chk("oow_ld_err", {31'h0, r_errd}, 32'h1);
    chk("oow_ld_done", r_ldn, 1);
    access(D0, 1'b0, 1'b1, 32'h0001_0000, 32'hCAFEF00D, 4'hF, 0);
    chk("oow_st_err", {31'h0, r_errd}, 32'h1);
    chk("oow_st_done", r_sdn, 1);
    access(D0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 0);
    chk("oow_st_nowrite", r_dat, 32'h01020304);
    chk("inwin_err", r_err, 0);

    access(D3, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    chk("ws3_st_lat", r_lat, 4);
    access(D3, 1'b0, 1'b1, 32'h22, 32'hA5A5A5A5, 4'b0100, 0);
    chk("ws3_byte_lat", r_lat, 4);
    chk("ws3_byte_busy", r_nb, 4);
    access(D3, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    chk("ws3_ld_lat", r_lat, 4);
    chk("ws3_byte_merge", r_dat, 32'h11A53344);

    access(D3, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 1);
    chk("clash_ld_done", r_ldn, 1);
    chk("clash_st_done", r_sdn, 0);
    chk("clash_err_pulses", r_err, 2);
    chk("clash_ld_data", r_dat, 32'h11A53344);
    access(D3, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    chk("clash_nowrite", r_dat, 32'h11A53344);

    ns = 0;
    t_addr[D3] = 32'h20;
    t_ds[D3]   = 32'h55555555;
    t_sel[D3]  = 4'hF;
    t_st[D3]   = 1'b1;
    step();
    t_st[D3] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (sdn[D3]) ns++;
    end
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      if (sdn[D3]) ns++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (sdn[D3]) ns++;
    end
    chk("rst_mid_no_done", ns, 0);
    wait_init();
    access(D3, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 0);
    chk("rst_mid_nowrite", r_dat, INIT_EN ? 32'h0 : 32'h11A53344);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
